// File: rtl/epp_bram_pkg.sv
// rtl/epp_bram_pkg.sv - register map, FSM encoding and access decoding for the EPP BRAM bridge
package epp_bram_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_ADRL = 3'd1;
  localparam logic [2:0] REG_ADRH = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam logic [7:0] CTRL_RST      = 8'h01;
  localparam int         CTRL_INC_BIT  = 0;
  localparam int         STAT_WRAP_BIT = 0;
  localparam int         STAT_OVR_BIT  = 1;
  localparam int         STAT_BUSY_BIT = 7;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_INCR, S_PF_REQ, S_PF_CAP} state_t;
  typedef enum logic [2:0] {K_NONE, K_DATA_WR, K_DATA_RD, K_REG_WR, K_STAT_WR} kind_t;

  // Only accesses that change state are given a kind; the rest are K_NONE.
  function automatic kind_t decode_kind(input logic rd, input logic [2:0] reg_idx);
    if (rd) return (reg_idx == REG_DATA) ? K_DATA_RD : K_NONE;
    case (reg_idx)
      REG_DATA:                     return K_DATA_WR;
      REG_ADRL, REG_ADRH, REG_CTRL: return K_REG_WR;
      REG_STAT:                     return K_STAT_WR;
      default:                      return K_NONE;
    endcase
  endfunction

endpackage

// File: rtl/epp_stb_sync.sv
// rtl/epp_stb_sync.sv - 3-FF synchroniser for the EPP data strobe with rising-edge pulse
module epp_stb_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_stb,
  output logic o_rise
);

  logic [2:0] r_sync;

  // Reset to all-ones so a strobe held high through reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rstn) r_sync <= 3'b111;
    else       r_sync <= {r_sync[1:0], i_stb};
  end

  assign o_rise = (r_sync[2:1] == 2'b01);

endmodule

// File: rtl/epp_bram_bridge.sv
// rtl/epp_bram_bridge.sv - EPP register port onto byte-wide banked BRAM with read prefetch
module epp_bram_bridge
  import epp_bram_pkg::*;
#(
  parameter int ADR_W = 11,
  parameter int NBANK = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stbData,
  input  logic                 ctrlWr,
  input  logic                 selBram,
  input  logic [6:0]           busEppAdrIn,
  input  logic [7:0]           busEppIn,
  output logic [7:0]           busEppOut,
  output logic [ADR_W-1:0]     bramAdr,
  output logic [7:0]           bramDout,
  input  logic [8*NBANK-1:0]   bramDin,
  output logic [NBANK-1:0]     bramEn,
  output logic [NBANK-1:0]     bramWe,
  output logic                 busy
);

  state_t             r_state;
  logic [ADR_W-1:0]   r_adr;
  logic               r_ctrl_inc;
  logic [2:0]         r_bank;
  logic               r_wrap;
  logic               r_ovr;
  logic [7:0]         r_rd_hold;
  logic [7:0]         r_dout;
  logic [NBANK-1:0]   r_en;
  logic [NBANK-1:0]   r_we;
  logic               r_pend_valid;
  kind_t              r_pend_kind;
  logic [2:0]         r_pend_reg;
  logic [7:0]         r_pend_data;

  logic               w_rise;
  kind_t              w_live_kind;
  kind_t              w_svc_kind;
  logic [2:0]         w_svc_reg;
  logic [7:0]         w_svc_data;
  logic [2:0]         w_svc_bank;
  logic [NBANK-1:0]   w_bank_oh;
  logic [NBANK-1:0]   w_svc_oh;
  logic [7:0]         w_din_sel;
  logic [7:0]         w_stat;
  logic [7:0]         w_rd_mux;
  logic [15:0]        w_adr16;
  logic               w_unused;

  function automatic logic [2:0] clamp_bank(input logic [2:0] idx);
    return (int'(idx) >= NBANK) ? 3'(NBANK - 1) : idx;
  endfunction

  epp_stb_sync u_stb_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_stb  (stbData),
    .o_rise (w_rise)
  );

  assign w_live_kind = (w_rise && selBram) ? decode_kind(ctrlWr, busEppAdrIn[2:0]) : K_NONE;

  // In IDLE a held pending access always goes ahead of a live one.
  assign w_svc_kind = r_pend_valid ? r_pend_kind : w_live_kind;
  assign w_svc_reg  = r_pend_valid ? r_pend_reg  : busEppAdrIn[2:0];
  assign w_svc_data = r_pend_valid ? r_pend_data : busEppIn;
  assign w_svc_bank = (w_svc_kind == K_REG_WR && w_svc_reg == REG_CTRL)
                    ? clamp_bank(w_svc_data[6:4]) : r_bank;

  assign w_bank_oh = NBANK'(1) << r_bank;
  assign w_svc_oh  = NBANK'(1) << w_svc_bank;

  always_comb begin
    w_din_sel = 8'h00;
    for (int k = 0; k < NBANK; k++) begin
      if (r_bank == 3'(k)) w_din_sel = bramDin[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_adr        <= '0;
      r_ctrl_inc   <= CTRL_RST[CTRL_INC_BIT];
      r_bank       <= CTRL_RST[6:4];
      r_wrap       <= 1'b0;
      r_ovr        <= 1'b0;
      r_rd_hold    <= 8'h00;
      r_dout       <= 8'h00;
      r_en         <= '0;
      r_we         <= '0;
      r_pend_valid <= 1'b0;
      r_pend_kind  <= K_NONE;
      r_pend_reg   <= 3'd0;
      r_pend_data  <= 8'h00;
    end else begin
      r_en <= '0;
      r_we <= '0;

      if (r_state != S_IDLE && w_live_kind != K_NONE) begin
        if (r_pend_valid) begin
          r_ovr <= 1'b1;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_kind  <= w_live_kind;
          r_pend_reg   <= busEppAdrIn[2:0];
          r_pend_data  <= busEppIn;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend_valid) begin
            r_pend_valid <= (w_live_kind != K_NONE);
            r_pend_kind  <= w_live_kind;
            r_pend_reg   <= busEppAdrIn[2:0];
            r_pend_data  <= busEppIn;
          end
          case (w_svc_kind)
            K_DATA_WR: begin
              r_state <= S_WRITE;
              r_en    <= w_bank_oh;
              r_we    <= w_bank_oh;
              r_dout  <= w_svc_data;
            end
            K_DATA_RD: r_state <= S_INCR;
            K_REG_WR: begin
              case (w_svc_reg)
                REG_ADRL: r_adr[7:0] <= w_svc_data;
                REG_ADRH: r_adr[ADR_W-1:8] <= w_svc_data[ADR_W-9:0];
                REG_CTRL: begin
                  r_ctrl_inc <= w_svc_data[CTRL_INC_BIT];
                  r_bank     <= w_svc_bank;
                end
                default: ;
              endcase
              r_state <= S_PF_REQ;
              r_en    <= w_svc_oh;
            end
            K_STAT_WR: begin
              r_wrap <= 1'b0;
              r_ovr  <= 1'b0;
            end
            default: ;
          endcase
        end
        S_WRITE: r_state <= S_INCR;
        S_INCR: begin
          if (r_ctrl_inc) begin
            r_adr <= r_adr + ADR_W'(1);
            if (&r_adr) r_wrap <= 1'b1;
          end
          r_state <= S_PF_REQ;
          r_en    <= w_bank_oh;
        end
        S_PF_REQ: r_state <= S_PF_CAP;
        S_PF_CAP: begin
          r_rd_hold <= w_din_sel;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_adr16 = 16'(r_adr);

  always_comb begin
    w_stat = 8'h00;
    w_stat[STAT_WRAP_BIT] = r_wrap;
    w_stat[STAT_OVR_BIT]  = r_ovr;
    w_stat[STAT_BUSY_BIT] = busy;
    w_rd_mux = 8'h00;
    case (busEppAdrIn[2:0])
      REG_DATA: w_rd_mux = r_rd_hold;
      REG_ADRL: w_rd_mux = w_adr16[7:0];
      REG_ADRH: w_rd_mux = w_adr16[15:8];
      REG_CTRL: w_rd_mux = {1'b0, r_bank, 3'b000, r_ctrl_inc};
      REG_STAT: w_rd_mux = w_stat;
      default:  w_rd_mux = 8'h00;
    endcase
  end

  assign w_unused  = ^busEppAdrIn[6:3];
  assign busEppOut = selBram ? w_rd_mux : 8'h00;
  assign busy      = (r_state != S_IDLE);
  assign bramAdr   = r_adr;
  assign bramDout  = r_dout;
  assign bramEn    = r_en;
  assign bramWe    = r_we;

endmodule

// File: tb/tb_epp_bram_bridge.sv
// tb/tb_epp_bram_bridge.sv - self-checking bench for epp_bram_bridge with a BRAM model and write scoreboard
module tb_epp_bram_bridge;

  localparam logic [2:0] R_DATA = 3'd0;
  localparam logic [2:0] R_ADRL = 3'd1;
  localparam logic [2:0] R_ADRH = 3'd2;
  localparam logic [2:0] R_CTRL = 3'd3;
  localparam logic [2:0] R_STAT = 3'd4;

  typedef struct packed {
    logic [2:0]  bank;
    logic [10:0] adr;
    logic [7:0]  data;
  } wr_exp_t;

  logic        clk;
  logic        rstn;
  logic        stbData;
  logic        ctrlWr;
  logic        selBram;
  logic [6:0]  busEppAdrIn;
  logic [7:0]  busEppIn;
  logic [7:0]  busEppOut;
  logic [10:0] bramAdr;
  logic [7:0]  bramDout;
  logic [15:0] bramDin;
  logic [1:0]  bramEn;
  logic [1:0]  bramWe;
  logic        busy;

  logic [7:0]  mem [2][2048];
  logic [7:0]  din_r [2];
  wr_exp_t     wr_q[$];
  logic [7:0]  rd_q[$];
  wr_exp_t     mon_e;
  logic [1:0]  mon_we;
  int          n_pass;
  int          n_total;

  epp_bram_bridge #(.ADR_W(11), .NBANK(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stbData     (stbData),
    .ctrlWr      (ctrlWr),
    .selBram     (selBram),
    .busEppAdrIn (busEppAdrIn),
    .busEppIn    (busEppIn),
    .busEppOut   (busEppOut),
    .bramAdr     (bramAdr),
    .bramDout    (bramDout),
    .bramDin     (bramDin),
    .bramEn      (bramEn),
    .bramWe      (bramWe),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous BRAM, one-cycle read latency
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bramEn[k]) begin
        din_r[k] <= mem[k][bramAdr];
        if (bramWe[k]) mem[k][bramAdr] = bramDout;
      end
    end
  end
  assign bramDin = {din_r[1], din_r[0]};

  always @(negedge clk) begin
    if (bramWe != 2'b00) begin
      n_total++;
      if (wr_q.size() == 0) begin
        $display("FAIL bram_write_unexpected: we=%b adr=%h data=%h, required no write", bramWe, bramAdr, bramDout);
      end else begin
        mon_e  = wr_q.pop_front();
        mon_we = 2'b01 << mon_e.bank;
        if (bramWe !== mon_we || bramAdr !== mon_e.adr || bramDout !== mon_e.data)
          $display("FAIL bram_write: we=%b adr=%h data=%h, required we=%b adr=%h data=%h",
                   bramWe, bramAdr, bramDout, mon_we, mon_e.adr, mon_e.data);
        else n_pass++;
      end
    end
  end

  task automatic epp_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    selBram = 1'b1; ctrlWr = 1'b0; busEppAdrIn = {4'b0, a}; busEppIn = d; stbData = 1'b0;
    repeat (3) @(negedge clk);
    stbData = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic epp_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    selBram = 1'b1; ctrlWr = 1'b1; busEppAdrIn = {4'b0, a}; stbData = 1'b0;
    repeat (3) @(negedge clk);
    d = busEppOut;
    stbData = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int bad;
    rstn = 1'b0; stbData = 1'b1; selBram = 1'b0; ctrlWr = 1'b1;
    busEppAdrIn = {4'b0, R_CTRL}; busEppIn = 8'h00;
    repeat (4) @(negedge clk);
    n_total++;
    if (busEppOut !== 8'h00) $display("FAIL reset_out_unselected: got %h required %h", busEppOut, 8'h00);
    else n_pass++;
    rstn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || bramEn !== 2'b00 || bramWe !== 2'b00) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL reset_no_spurious_edge: %0d active cycles, required 0", bad);
    else n_pass++;
    n_total++;
    if (bramAdr !== 11'h000) $display("FAIL reset_adr: got %h required %h", bramAdr, 11'h000);
    else n_pass++;
    epp_read(R_CTRL, v);
    n_total++;
    if (v !== 8'h01) $display("FAIL reset_ctrl: got %h required %h", v, 8'h01);
    else n_pass++;
    epp_read(R_STAT, v);
    n_total++;
    if (v !== 8'h00) $display("FAIL reset_stat: got %h required %h", v, 8'h00);
    else n_pass++;
  endtask

  task automatic test_wrap_write();
    logic [7:0] v;
    epp_write(R_ADRL, 8'hFE);
    epp_write(R_ADRH, 8'h07);
    wr_q.push_back('{3'd0, 11'h7FE, 8'hAA});
    epp_write(R_DATA, 8'hAA);
    wr_q.push_back('{3'd0, 11'h7FF, 8'hBB});
    epp_write(R_DATA, 8'hBB);
    wr_q.push_back('{3'd0, 11'h000, 8'hCC});
    epp_write(R_DATA, 8'hCC);
    epp_read(R_STAT, v);
    n_total++;
    if (v !== 8'h01) $display("FAIL wrap_stat: got %h required %h", v, 8'h01);
    else n_pass++;
    epp_read(R_ADRL, v);
    n_total++;
    if (v !== 8'h01) $display("FAIL wrap_adrl: got %h required %h", v, 8'h01);
    else n_pass++;
    n_total++;
    if (mem[0][11'h7FF] !== 8'hBB || mem[0][11'h000] !== 8'hCC)
      $display("FAIL wrap_mem: got %h %h required bb cc", mem[0][11'h7FF], mem[0][11'h000]);
    else n_pass++;
  endtask

  task automatic test_read_burst();
    logic [7:0] v;
    logic [7:0] e;
    epp_write(R_STAT, 8'hFF);
    epp_read(R_STAT, v);
    n_total++;
    if (v !== 8'h00) $display("FAIL stat_clear: got %h required %h", v, 8'h00);
    else n_pass++;
    mem[1][11'h010] = 8'h11; mem[1][11'h011] = 8'h22; mem[1][11'h012] = 8'h33;
    epp_write(R_CTRL, 8'h71);
    epp_read(R_CTRL, v);
    n_total++;
    if (v !== 8'h11) $display("FAIL ctrl_bank_clamp: got %h required %h", v, 8'h11);
    else n_pass++;
    epp_write(R_ADRL, 8'h10);
    epp_write(R_ADRH, 8'h00);
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      epp_read(R_DATA, v);
      e = rd_q.pop_front();
      n_total++;
      if (v !== e) $display("FAIL read_burst_%0d: got %h required %h", i, v, e);
      else n_pass++;
    end
    epp_read(R_ADRL, v);
    n_total++;
    if (v !== 8'h13) $display("FAIL read_burst_adr: got %h required %h", v, 8'h13);
    else n_pass++;
  endtask

  task automatic test_no_incr();
    logic [7:0] v;
    epp_write(R_CTRL, 8'h00);
    epp_write(R_ADRL, 8'h20);
    epp_write(R_ADRH, 8'h00);
    wr_q.push_back('{3'd0, 11'h020, 8'h55});
    epp_write(R_DATA, 8'h55);
    wr_q.push_back('{3'd0, 11'h020, 8'h66});
    epp_write(R_DATA, 8'h66);
    n_total++;
    if (mem[0][11'h020] !== 8'h66) $display("FAIL noinc_mem: got %h required %h", mem[0][11'h020], 8'h66);
    else n_pass++;
    epp_read(R_DATA, v);
    n_total++;
    if (v !== 8'h66) $display("FAIL noinc_prefetch: got %h required %h", v, 8'h66);
    else n_pass++;
    epp_read(R_ADRL, v);
    n_total++;
    if (v !== 8'h20) $display("FAIL noinc_adr: got %h required %h", v, 8'h20);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    epp_write(R_CTRL, 8'h01);
    epp_write(R_ADRH, 8'h01);
    epp_write(R_ADRL, 8'h00);
    epp_write(R_STAT, 8'h00);
    wr_q.push_back('{3'd0, 11'h100, 8'h71});
    wr_q.push_back('{3'd0, 11'h101, 8'h72});
    @(negedge clk);
    selBram = 1'b1; ctrlWr = 1'b0; busEppAdrIn = {4'b0, R_DATA}; busEppIn = 8'h71; stbData = 1'b0;
    repeat (2) @(negedge clk);
    stbData = 1'b1;
    @(negedge clk); stbData = 1'b0;
    @(negedge clk); stbData = 1'b1;
    @(negedge clk); stbData = 1'b0; busEppIn = 8'h72;
    @(negedge clk); stbData = 1'b1;
    @(negedge clk); busEppIn = 8'h73;
    @(negedge clk);
    @(negedge clk); busEppAdrIn = {4'b0, R_STAT};
    @(negedge clk);
    v = busEppOut;
    n_total++;
    if (v !== 8'h82) $display("FAIL overrun_busy_stat: got %h required %h", v, 8'h82);
    else n_pass++;
    repeat (12) @(negedge clk);
    epp_read(R_STAT, v);
    n_total++;
    if (v !== 8'h02) $display("FAIL overrun_stat: got %h required %h", v, 8'h02);
    else n_pass++;
    n_total++;
    if (mem[0][11'h102] !== 8'h00) $display("FAIL overrun_dropped: got %h required %h", mem[0][11'h102], 8'h00);
    else n_pass++;
    epp_read(R_ADRL, v);
    n_total++;
    if (v !== 8'h02) $display("FAIL overrun_adr: got %h required %h", v, 8'h02);
    else n_pass++;
    epp_write(R_STAT, 8'h5A);
    epp_read(R_STAT, v);
    n_total++;
    if (v !== 8'h00) $display("FAIL overrun_clear: got %h required %h", v, 8'h00);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] v;
    logic found;
    epp_write(R_CTRL, 8'h00);
    epp_write(R_ADRH, 8'h00);
    epp_write(R_ADRL, 8'h55);
    wr_q.push_back('{3'd0, 11'h055, 8'h99});
    @(negedge clk);
    selBram = 1'b1; ctrlWr = 1'b0; busEppAdrIn = {4'b0, R_DATA}; busEppIn = 8'h99; stbData = 1'b0;
    repeat (3) @(negedge clk);
    stbData = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bramWe != 2'b00) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL abort_we_seen: got no write cycle within 10 clocks, required one");
    else n_pass++;
    rstn = 1'b0;
    @(negedge clk);
    n_total++;
    if (bramWe !== 2'b00 || bramEn !== 2'b00 || busy !== 1'b0 || bramAdr !== 11'h000)
      $display("FAIL abort_outputs: we=%b en=%b busy=%b adr=%h required 00 00 0 000", bramWe, bramEn, busy, bramAdr);
    else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    epp_read(R_CTRL, v);
    n_total++;
    if (v !== 8'h01) $display("FAIL abort_ctrl: got %h required %h", v, 8'h01);
    else n_pass++;
    epp_read(R_ADRL, v);
    n_total++;
    if (v !== 8'h00) $display("FAIL abort_adrl: got %h required %h", v, 8'h00);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rstn = 1'b0; stbData = 1'b1; ctrlWr = 1'b1; selBram = 1'b0;
    busEppAdrIn = 7'h00; busEppIn = 8'h00;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 2048; a++) mem[k][a] = 8'h00;
    end
    test_reset();
    test_wrap_write();
    test_read_burst();
    test_no_incr();
    test_back_to_back();
    test_reset_abort();
    n_total++;
    if (wr_q.size() != 0) $display("FAIL scoreboard_drained: %0d writes outstanding, required 0", wr_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
